edge_color_mask_stream_merge: RTL and testbench

- Streaming successor to the windowed edge/colour merge stage in the paddle-localization path.
- Accepts raster-order pixels carrying colour-mask bits, a pixel-valid bit and edge data.
- Builds the M_SIZE x M_SIZE neighbourhood internally using line buffers and masks window positions that fall outside the image.
- Counts each colour against a threshold, gates the centre pixel's edge data (AND or OR across colours), and flushes the frame tail itself.

---
 rtl/edge_color_mask_stream_merge.sv | 277 +++++++++++++++++++++++++++
 tb/tb_edge_color_mask_stream_merge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_color_mask_stream_merge.sv
`default_nettype none
// ============================================================================
// Module   : edge_color_mask_stream_merge
// Function : Raster-stream M_SIZE x M_SIZE colour-count window that gates the
//            centre pixel's edge data; self-flushes the frame tail.
// Revision : 1.0 - initial release
// ============================================================================
module edge_color_mask_stream_merge #(
    parameter int IMG_WIDTH       = 640,
    parameter int IMG_HEIGHT      = 480,
    parameter int M_SIZE          = 11,
    parameter int M_THRESHOLD     = 2,
    parameter int COLORS          = 2,
    parameter int EDGE_DATA_WIDTH = 1,
    parameter int MERGE_MODE      = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sof,
    input  logic                       in_pix_valid,
    input  logic [COLORS-1:0]          in_color,
    input  logic [EDGE_DATA_WIDTH-1:0] in_edge,
    output logic                       out_valid,
    output logic                       out_sof,
    output logic                       out_eof,
    output logic [EDGE_DATA_WIDTH-1:0] out_edge,
    output logic [COLORS-1:0]          out_achieved
);

    localparam int c_H     = M_SIZE / 2;
    localparam int c_EW    = 1 + COLORS + EDGE_DATA_WIDTH;
    localparam int c_CW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int c_RW    = $clog2(IMG_HEIGHT + c_H + 1);
    localparam int c_FLUSH = c_H * IMG_WIDTH + c_H;
    localparam int c_FW    = $clog2(c_FLUSH + 1);
    localparam int c_SW    = $clog2(M_SIZE + 1);
    localparam int c_NW    = $clog2(M_SIZE * M_SIZE + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [c_CW-1:0]   col_q, col_d;
    logic [c_RW-1:0]   row_q, row_d;
    logic [c_FW-1:0]   flush_q, flush_d;

    logic              w_accept;
    logic              w_adv;
    logic [c_CW-1:0]   w_pos_c;
    logic [c_RW-1:0]   w_pos_r;
    logic [c_EW-1:0]   w_entry;

    assign in_ready = (state_q != S_FLUSH);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        flush_d = flush_q;
        w_adv   = 1'b0;
        w_pos_c = col_q;
        w_pos_r = row_q;
        w_entry = {in_pix_valid, in_color, in_edge};
        case (state_q)
            S_IDLE: begin
                if (w_accept && in_sof) begin
                    w_adv   = 1'b1;
                    w_pos_c = '0;
                    w_pos_r = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_accept) begin
                    w_adv = 1'b1;
                    if (in_sof) begin
                        w_pos_c = '0;
                        w_pos_r = '0;
                    end
                    if (w_pos_r == c_RW'(IMG_HEIGHT - 1) && w_pos_c == c_CW'(IMG_WIDTH - 1)) begin
                        state_d = S_FLUSH;
                        flush_d = c_FW'(c_FLUSH);
                    end
                end
            end
            S_FLUSH: begin
                // Tail pixels carry pix_valid = 0 and edge = 0.
                w_adv   = 1'b1;
                w_entry = '0;
                flush_d = flush_q - 1'b1;
                if (flush_q == c_FW'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (w_adv) begin
            if (w_pos_c == c_CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = w_pos_r + 1'b1;
            end else begin
                col_d = w_pos_c + 1'b1;
                row_d = w_pos_r;
            end
        end
    end

    // Centre lags the written position by H rows and H columns in raster order.
    logic [c_CW-1:0] w_cx;
    logic [c_RW-1:0] w_cy;
    logic            w_ctr_ok;

    always_comb begin
        if (int'(w_pos_c) >= c_H) begin
            w_cx     = w_pos_c - c_CW'(c_H);
            w_cy     = w_pos_r - c_RW'(c_H);
            w_ctr_ok = (int'(w_pos_r) >= c_H);
        end else begin
            w_cx     = w_pos_c + c_CW'(IMG_WIDTH - c_H);
            w_cy     = w_pos_r - c_RW'(c_H + 1);
            w_ctr_ok = (int'(w_pos_r) >= c_H + 1);
        end
    end

    logic [c_EW-1:0] lb_mem  [M_SIZE-1][IMG_WIDTH];
    logic [c_EW-1:0] w_col_in[M_SIZE];
    logic [c_EW-1:0] win_q   [M_SIZE][M_SIZE];
    logic [c_EW-1:0] win_d   [M_SIZE][M_SIZE];

    always_comb begin
        w_col_in[0] = w_entry;
        for (int k = 1; k < M_SIZE; k++) begin
            w_col_in[k] = lb_mem[k-1][w_pos_c];
        end
    end

    always_comb begin
        for (int i = 0; i < M_SIZE; i++) begin
            for (int j = 0; j < M_SIZE - 1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
            win_d[i][M_SIZE-1] = w_col_in[M_SIZE-1-i];
        end
    end

    logic [M_SIZE-1:0] w_row_ok;
    logic [M_SIZE-1:0] w_col_ok;

    always_comb begin
        for (int i = 0; i < M_SIZE; i++) begin
            w_row_ok[i] = (int'(w_cy) - c_H + i >= 0) && (int'(w_cy) - c_H + i < IMG_HEIGHT);
            w_col_ok[i] = (int'(w_cx) - c_H + i >= 0) && (int'(w_cx) - c_H + i < IMG_WIDTH);
        end
    end

    logic [c_SW-1:0]            s1_colsum_q[M_SIZE][COLORS];
    logic [c_SW-1:0]            s1_colsum_d[M_SIZE][COLORS];
    logic [EDGE_DATA_WIDTH-1:0] s1_edge_q, s1_edge_d;
    logic                       s1_valid_q, s1_valid_d;
    logic                       s1_sof_q, s1_sof_d;
    logic                       s1_eof_q, s1_eof_d;

    always_comb begin
        for (int j = 0; j < M_SIZE; j++) begin
            for (int c = 0; c < COLORS; c++) begin
                s1_colsum_d[j][c] = '0;
                for (int i = 0; i < M_SIZE; i++) begin
                    if (w_row_ok[i] && w_col_ok[j] && win_d[i][j][c_EW-1]) begin
                        s1_colsum_d[j][c] = s1_colsum_d[j][c]
                                          + c_SW'(win_d[i][j][EDGE_DATA_WIDTH+c]);
                    end
                end
            end
        end
        s1_edge_d  = win_d[c_H][c_H][EDGE_DATA_WIDTH-1:0];
        s1_valid_d = w_adv && w_ctr_ok;
        s1_sof_d   = (w_cy == '0) && (w_cx == '0);
        s1_eof_d   = (w_cy == c_RW'(IMG_HEIGHT - 1)) && (w_cx == c_CW'(IMG_WIDTH - 1));
    end

    logic [c_NW-1:0]   w_total[COLORS];
    logic [COLORS-1:0] w_ach;
    logic              w_gate;

    always_comb begin
        for (int c = 0; c < COLORS; c++) begin
            w_total[c] = '0;
            for (int j = 0; j < M_SIZE; j++) begin
                w_total[c] = w_total[c] + c_NW'(s1_colsum_q[j][c]);
            end
        end
    end

    generate
        if (M_THRESHOLD == 0) begin : g_thr_zero
            assign w_ach = '1;
        end else begin : g_thr_cmp
            always_comb begin
                for (int c = 0; c < COLORS; c++) begin
                    w_ach[c] = (int'(w_total[c]) >= M_THRESHOLD);
                end
            end
        end
    endgenerate

    assign w_gate = (MERGE_MODE == 0) ? (&w_ach) : (|w_ach);

    logic                       out_valid_q, out_valid_d;
    logic                       out_sof_q, out_sof_d;
    logic                       out_eof_q, out_eof_d;
    logic [EDGE_DATA_WIDTH-1:0] out_edge_q, out_edge_d;
    logic [COLORS-1:0]          out_achieved_q, out_achieved_d;

    always_comb begin
        out_valid_d    = s1_valid_q;
        out_sof_d      = s1_valid_q && s1_sof_q;
        out_eof_d      = s1_valid_q && s1_eof_q;
        out_edge_d     = (s1_valid_q && w_gate) ? s1_edge_q : '0;
        out_achieved_d = s1_valid_q ? w_ach : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            col_q          <= '0;
            row_q          <= '0;
            flush_q        <= '0;
            s1_valid_q     <= 1'b0;
            s1_sof_q       <= 1'b0;
            s1_eof_q       <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            out_eof_q      <= 1'b0;
            out_edge_q     <= '0;
            out_achieved_q <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            flush_q        <= flush_d;
            s1_valid_q     <= s1_valid_d;
            s1_sof_q       <= s1_sof_d;
            s1_eof_q       <= s1_eof_d;
            out_valid_q    <= out_valid_d;
            out_sof_q      <= out_sof_d;
            out_eof_q      <= out_eof_d;
            out_edge_q     <= out_edge_d;
            out_achieved_q <= out_achieved_d;
        end
    end

    // Storage and datapath payload: stale contents are masked by coordinates.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            for (int k = 0; k < M_SIZE - 1; k++) begin
                lb_mem[k][w_pos_c] <= w_col_in[k];
            end
            win_q <= win_d;
        end
        s1_colsum_q <= s1_colsum_d;
        s1_edge_q   <= s1_edge_d;
    end

    assign out_valid    = out_valid_q;
    assign out_sof      = out_sof_q;
    assign out_eof      = out_eof_q;
    assign out_edge     = out_edge_q;
    assign out_achieved = out_achieved_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_color_mask_stream_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_color_mask_stream_merge
// Function : Scoreboard bench driving four parameter variants in lock-step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_color_mask_stream_merge;

    localparam int W    = 8;
    localparam int HT   = 6;
    localparam int M    = 3;
    localparam int HH   = M / 2;
    localparam int D    = HH * W + HH;
    localparam int NPIX = W * HT;
    localparam int NI   = 4;

    typedef struct {
        int           cyc;
        bit           sof;
        bit           eof;
        logic [NI-1:0]   edg;
        logic [2*NI-1:0] ach;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic in_sof;
    logic in_pix_valid;
    logic [1:0] in_color;
    logic [0:0] in_edge;

    logic [NI-1:0] rdy;
    logic [NI-1:0] ov;
    logic [NI-1:0] osof;
    logic [NI-1:0] oeof;
    logic [NI-1:0] oedge;
    logic [1:0]    oach [NI];
    logic [2*NI-1:0] ach_all;

    assign ach_all = {oach[3], oach[2], oach[1], oach[0]};

    always #5 clk = ~clk;

    function automatic int thr_of(int k);
        return (k == 1) ? 5 : ((k == 3) ? 1 : 2);
    endfunction

    function automatic int mode_of(int k);
        return (k == 2) ? 1 : 0;
    endfunction

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            edge_color_mask_stream_merge #(
                .IMG_WIDTH      (W),
                .IMG_HEIGHT     (HT),
                .M_SIZE         (M),
                .M_THRESHOLD    ((g == 1) ? 5 : ((g == 3) ? 1 : 2)),
                .COLORS         (2),
                .EDGE_DATA_WIDTH(1),
                .MERGE_MODE     ((g == 2) ? 1 : 0)
            ) u_dut (
                .clk         (clk),
                .reset       (reset),
                .in_valid    (in_valid),
                .in_ready    (rdy[g]),
                .in_sof      (in_sof),
                .in_pix_valid(in_pix_valid),
                .in_color    (in_color),
                .in_edge     (in_edge),
                .out_valid   (ov[g]),
                .out_sof     (osof[g]),
                .out_eof     (oeof[g]),
                .out_edge    (oedge[g:g]),
                .out_achieved(oach[g])
            );
        end
    endgenerate

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    exp_t sbq[$];

    bit         f_pv  [NPIX];
    logic [1:0] f_col [NPIX];
    bit         f_edge[NPIX];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Direct neighbourhood count over the stored frame, clipped to the image.
    function automatic exp_t model(int idx);
        exp_t e;
        int y = idx / W;
        int x = idx % W;
        int cnt[2];
        logic [1:0] a;
        cnt[0] = 0;
        cnt[1] = 0;
        e.cyc = 0;
        e.sof = (idx == 0);
        e.eof = (idx == NPIX - 1);
        e.edg = '0;
        e.ach = '0;
        for (int dy = -HH; dy <= HH; dy++) begin
            for (int dx = -HH; dx <= HH; dx++) begin
                if (y + dy >= 0 && y + dy < HT && x + dx >= 0 && x + dx < W) begin
                    if (f_pv[(y + dy) * W + x + dx]) begin
                        cnt[0] += int'(f_col[(y + dy) * W + x + dx][0]);
                        cnt[1] += int'(f_col[(y + dy) * W + x + dx][1]);
                    end
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            a[0] = (cnt[0] >= thr_of(k));
            a[1] = (cnt[1] >= thr_of(k));
            e.ach[2*k +: 2] = a;
            e.edg[k] = f_edge[idx] && ((mode_of(k) == 1) ? (|a) : (&a));
        end
        return e;
    endfunction

    task automatic push_exp(input int idx);
        exp_t e;
        e = model(idx);
        e.cyc = cyc + 2;
        sbq.push_back(e);
    endtask

    task automatic set_frame(input int kind);
        for (int p = 0; p < NPIX; p++) begin
            case (kind)
                0: begin f_pv[p] = 1'b1; f_col[p] = 2'b11; f_edge[p] = 1'b1; end
                1: begin f_pv[p] = 1'b1; f_col[p] = 2'b01; f_edge[p] = 1'($urandom_range(0, 1)); end
                2, 3: begin
                    f_pv[p] = 1'b1; f_col[p] = 2'b00; f_edge[p] = 1'b1;
                    if (p == 2 * W + 7 || p == 3 * W + 0) begin
                        f_col[p] = 2'b11;
                        f_pv[p]  = (kind == 2);
                    end
                end
                default: begin
                    f_pv[p]   = ($urandom_range(0, 3) != 0);
                    f_col[p]  = 2'($urandom_range(0, 3));
                    f_edge[p] = 1'($urandom_range(0, 1));
                end
            endcase
        end
    endtask

    task automatic drive_pixels(input int n, input bit with_sof);
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
            in_valid     = 1'b1;
            in_sof       = with_sof && (p == 0);
            in_pix_valid = f_pv[p];
            in_color     = f_col[p];
            in_edge      = f_edge[p];
            if (with_sof && p >= D) push_exp(p - D);
            @(posedge clk);
        end
    endtask

    task automatic flush_and_drain();
        for (int k = 0; k < D; k++) begin
            @(negedge clk);
            in_sof = 1'b0;
            chk_val("flush_ready", rdy, 0);
            push_exp(NPIX - D + k);
            @(posedge clk);
        end
        @(negedge clk);
        chk_val("post_flush_ready", rdy, 4'hF);
        in_valid = 1'b0;
        for (int t = 0; t < 20 && sbq.size() != 0; t++) @(negedge clk);
        chk_val("drain", sbq.size(), 0);
    endtask

    task automatic run_frame(input int kind);
        int n0;
        set_frame(kind);
        n0 = n_out;
        drive_pixels(NPIX, 1'b1);
        flush_and_drain();
        chk_val("frame_count", n_out - n0, NPIX);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ov != '0) begin
                if (sbq.size() == 0) begin
                    chk_val("unexpected_out", ov, 0);
                end else begin
                    e = sbq.pop_front();
                    n_out++;
                    chk_val("valid_all", ov, 4'hF);
                    chk_val("latency", cyc, e.cyc);
                    chk_val("sof", osof, {NI{e.sof}});
                    chk_val("eof", oeof, {NI{e.eof}});
                    chk_val("edge", oedge, e.edg);
                    chk_val("achieved", ach_all, e.ach);
                end
            end
        end
    end

    initial begin
        int n0;
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_sof       = 1'b0;
        in_pix_valid = 1'b0;
        in_color     = 2'b00;
        in_edge      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_val("rst_valid", ov, 0);
        chk_val("rst_sof", osof, 0);
        chk_val("rst_eof", oeof, 0);
        chk_val("rst_edge", oedge, 0);
        chk_val("rst_achieved", ach_all, 0);
        chk_val("rst_ready", rdy, 4'hF);
        reset = 1'b0;

        // Pixels without a start-of-frame are dropped in IDLE.
        set_frame(0);
        n0 = n_out;
        drive_pixels(NPIX, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk_val("idle_no_out", n_out - n0, 0);

        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(3);

        // Abort after 20 pixels with reset, then a clean frame.
        set_frame(4);
        drive_pixels(20, 1'b1);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_val("abort_valid", ov, 0);
        chk_val("abort_ready", rdy, 4'hF);
        sbq.delete();
        reset = 1'b0;
        run_frame(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
